// File: rtl/logo_bouncer_if.sv
// Signal bundle between the frame-strobe side and the logo bouncer.
// The slave is the bouncer. The master drives ticks and pause and observes position and colour.
interface logo_bouncer_if;
  logic       frame_tick;
  logic       pause;
  logic [9:0] logo_x;
  logic [9:0] logo_y;
  logic [2:0] color_index;
  logic       bounce;
  logic       corner;

  modport master (
    output frame_tick, pause,
    input  logo_x, logo_y, color_index, bounce, corner
  );

  modport slave (
    input  frame_tick, pause,
    output logo_x, logo_y, color_index, bounce, corner
  );
endinterface

// File: rtl/logo_bouncer.sv
// Moves the logo one step per frame strobe, reflects it at the active-area walls,
// and advances the palette index on every bounce.
module logo_bouncer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned LOGO_W   = 96,
  parameter int unsigned LOGO_H   = 48,
  parameter int unsigned STEP     = 1,
  parameter int unsigned RESET_X  = 100,
  parameter int unsigned RESET_Y  = 50
) (
  input  logic            clk,
  input  logic            rst,
  logo_bouncer_if.slave   bus
);

  localparam logic [9:0] XMAX   = 10'(H_ACTIVE - LOGO_W);
  localparam logic [9:0] YMAX   = 10'(V_ACTIVE - LOGO_H);
  localparam logic [9:0] STEP_V = 10'(STEP);

  typedef struct packed {
    logic [9:0] pos;
    logic       neg;
    logic       hit;
  } axis_t;

  // Limits are compared before any add/subtract, so position never wraps.
  function automatic axis_t axis_next(input logic [9:0] pos, input logic neg,
                                      input logic [9:0] lim);
    axis_t r;
    r.pos = pos;
    r.neg = neg;
    r.hit = 1'b0;
    if (!neg) begin
      if (pos >= lim - STEP_V) begin
        r.pos = lim;
        r.neg = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = pos + STEP_V;
      end
    end else begin
      if (pos <= STEP_V) begin
        r.pos = '0;
        r.neg = 1'b0;
        r.hit = 1'b1;
      end else begin
        r.pos = pos - STEP_V;
      end
    end
    return r;
  endfunction

  logic [9:0] x_q, y_q;
  logic       neg_x_q, neg_y_q;
  logic [2:0] color_q;
  logic       bounce_q, corner_q;
  logic       tick_d;
  logic       step;
  axis_t      nx, ny;

  assign step = bus.frame_tick & ~tick_d & ~bus.pause;

  always_comb begin
    nx = axis_next(x_q, neg_x_q, XMAX);
    ny = axis_next(y_q, neg_y_q, YMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= 10'(RESET_X);
      y_q      <= 10'(RESET_Y);
      neg_x_q  <= 1'b0;
      neg_y_q  <= 1'b0;
      color_q  <= '0;
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
      tick_d   <= 1'b0;
    end else begin
      // Edge history tracks the strobe even while paused, so paused edges are dropped.
      tick_d   <= bus.frame_tick;
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
      if (step) begin
        x_q     <= nx.pos;
        y_q     <= ny.pos;
        neg_x_q <= nx.neg;
        neg_y_q <= ny.neg;
        if (nx.hit | ny.hit) begin
          color_q  <= color_q + 3'd1;
          bounce_q <= 1'b1;
          corner_q <= nx.hit & ny.hit;
        end
      end
    end
  end

  assign bus.logo_x      = x_q;
  assign bus.logo_y      = y_q;
  assign bus.color_index = color_q;
  assign bus.bounce      = bounce_q;
  assign bus.corner      = corner_q;

endmodule

// File: doc/logo_bouncer.md
Name: logo_bouncer

Overview:
- Upstream neighbour of the 8-entry colour palette block.
- Once per video frame it advances the bouncing logo's top-left position inside the active area and reverses direction at each wall.
- It advances a 3-bit colour index on every bounce; that index drives the palette's color_index input.
- The VGA timing generator supplies a frame strobe. The pixel renderer consumes logo_x, logo_y and the palette output.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- LOGO_W, 96, logo width in pixels
- LOGO_H, 48, logo height in pixels
- STEP, 1, pixels moved per axis per frame; must satisfy 1 <= STEP < min(XMAX, YMAX)
- RESET_X, 100, logo_x after reset; must be in 0..XMAX
- RESET_Y, 50, logo_y after reset; must be in 0..YMAX

Ports:
- clk  input  1  system/pixel clock
- rst  input  1  reset, asynchronous, active-high
- frame_tick  input  1  frame strobe from timing generator, asserted during vblank
- pause  input  1  when high, frame steps are suppressed
- logo_x  output  10  logo left edge, 0..XMAX
- logo_y  output  10  logo top edge, 0..YMAX
- color_index  output  3  palette index to the palette block
- bounce  output  1  one-cycle pulse on any wall hit
- corner  output  1  one-cycle pulse when both axes hit on the same step

Behaviour:
- Derived limits: XMAX = H_ACTIVE - LOGO_W (544); YMAX = V_ACTIVE - LOGO_H (432). All position arithmetic is 10-bit unsigned; compare before add/subtract so nothing wraps.
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst; every register is cleared or preset while rst=1, independent of clk.
- Reset values:
  - logo_x = RESET_X, logo_y = RESET_Y
  - dir_x = +, dir_y = + (internal)
  - color_index = 0, bounce = 0, corner = 0
  - tick_d (internal delayed copy of frame_tick) = 0
- Step detection:
  - step = frame_tick & ~tick_d & ~pause.
  - tick_d <= frame_tick every cycle, including while pause is high.
  - A tick held high for many cycles gives exactly one step.
  - A tick whose rising edge falls while pause=1 is lost; it is not deferred.
- Latency: all outputs update on the clk edge where step is true and are visible the following cycle.
- Per-axis update when step is true (X shown; Y identical with YMAX, dir_y):
  - dir + and x + STEP >= XMAX: x <= XMAX, dir <= -, hit_x = 1
  - dir + otherwise: x <= x + STEP
  - dir - and x <= STEP: x <= 0, dir <= +, hit_x = 1
  - dir - otherwise: x <= x - STEP
  - Landing exactly on an edge counts as a hit.
- Colour and pulses, on a step with hit_x | hit_y:
  - color_index <= color_index + 1, modulo 8 (7 wraps to 0); it advances once per step even if both axes hit.
  - bounce <= 1.
  - corner <= hit_x & hit_y.
- Pulse timing: bounce and corner are registered and return to 0 on the next cycle without a step. Without a step, all state holds.
- pause does not gate the async reset, and reset during any state returns immediately to the reset values.
- Outputs are always registered; there is no combinational path from any input to any output.

Test Plan:
- Reset release, then 10 frame_tick pulses (1-cycle high, spaced 20 cycles) -> logo_x=110, logo_y=60, color_index=0, bounce never high.
- Force logo_x=543, dir_x=+, logo_y=200, then one tick -> next cycle logo_x=544, bounce=1 for exactly 1 cycle, color_index 0->1, corner=0. Next tick -> logo_x=543.
- Force logo_x=543, logo_y=431, both directions +, then one tick -> logo_x=544, logo_y=432, color_index +1 only, bounce=1, corner=1.
- Left/top edge with STEP=3, logo_x=2, dir_x=- -> logo_x=0, dir_x=+, bounce=1. Next tick -> logo_x=3.
- Colour wrap: drive 8 wall hits -> color_index sequence 1,2,...,7,0.
- pause and held ticks:
  - frame_tick held high for 50 cycles -> exactly one step.
  - pause=1 across 5 tick edges -> no position change.
- Async reset: assert rst mid-cycle, between clock edges, after several steps -> outputs return to reset values before the next clk edge.
